// File: rtl/instr_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_if
//  Description : Fetch-stage bus bundle. Carries the instruction-memory
//                req/ack read channel and the valid/ready channel to decode.
//                The master side is the fetch stage.
//  Revision    : 1.0  initial release
// ============================================================================
interface instr_fetch_if;
    // Instruction-memory read channel
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    // Fetch-queue head toward decode
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        id_ready;

    modport master (
        output imem_req, imem_addr, if_valid, if_pc, if_instr,
        input  imem_ack, imem_rdata, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_pc, if_instr,
        output imem_ack, imem_rdata, id_ready
    );
endinterface
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch
//  Description : Instruction-fetch stage. Issues one word read at a time for
//                the current PC, queues returned {pc, instr} pairs toward
//                decode, advances the PC once per accepted fetch, discards
//                responses made stale by a branch flush and latches a sticky
//                fault if memory stops answering.
//  Revision    : 1.0  initial release
// ============================================================================
module instr_fetch #(
    parameter int DEPTH   = 2,
    parameter int TIMEOUT = 64
) (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic [31:0] pc_in,
    input  wire logic        flush,
    output logic             pc_write_en,
    output logic             fetch_fault,
    instr_fetch_if.master    bus
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam int c_WD_W  = $clog2(TIMEOUT + 1);

    localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(DEPTH);
    localparam logic [c_WD_W-1:0]  c_WD_LAST = c_WD_W'(TIMEOUT - 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_REQ   = 2'd1;
    localparam logic [1:0] c_ST_DROP  = 2'd2;
    localparam logic [1:0] c_ST_FAULT = 2'd3;

    logic [1:0]         r_state;
    logic               r_req;
    logic [31:0]        r_addr;
    logic               r_fault;
    logic [c_WD_W-1:0]  r_wdog;

    logic [31:0]        r_mem_pc    [DEPTH];
    logic [31:0]        r_mem_instr [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic w_ack_in_req;
    logic w_push;
    logic w_pop;
    logic w_flush_q;

    // Only an ack for a live request counts; a flush on the same cycle voids it.
    assign w_ack_in_req = (r_state == c_ST_REQ) & bus.imem_ack;
    assign w_push       = w_ack_in_req & ~flush;
    assign w_pop        = (r_count != '0) & bus.id_ready;
    assign w_flush_q    = flush & (r_state != c_ST_FAULT);

    assign pc_write_en  = reset & (flush | w_ack_in_req);

    assign bus.imem_req  = r_req;
    assign bus.imem_addr = r_addr;
    assign bus.if_valid  = (r_count != '0);
    assign bus.if_pc     = r_mem_pc[r_rd_ptr];
    assign bus.if_instr  = r_mem_instr[r_rd_ptr];
    assign fetch_fault   = r_fault;

    // Request FSM with watchdog; DROP waits out a request orphaned by a flush.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= c_ST_IDLE;
            r_req   <= 1'b0;
            r_addr  <= '0;
            r_fault <= 1'b0;
            r_wdog  <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_wdog <= '0;
                    if (!flush && (r_count < c_FULL)) begin
                        r_addr  <= pc_in;
                        r_req   <= 1'b1;
                        r_state <= c_ST_REQ;
                    end
                end
                c_ST_REQ, c_ST_DROP: begin
                    if (bus.imem_ack) begin
                        r_req   <= 1'b0;
                        r_wdog  <= '0;
                        r_state <= c_ST_IDLE;
                    end else if (r_wdog == c_WD_LAST) begin
                        r_req   <= 1'b0;
                        r_fault <= 1'b1;
                        r_wdog  <= '0;
                        r_state <= c_ST_FAULT;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                        if (flush) begin
                            r_state <= c_ST_DROP;
                        end
                    end
                end
                c_ST_FAULT: begin
                    r_req <= 1'b0;
                end
                default: begin
                    r_req   <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Fetch queue: circular buffer; a flush empties it and wins over a pop.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_pc[i]    <= '0;
                r_mem_instr[i] <= '0;
            end
        end else if (w_flush_q) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem_pc[r_wr_ptr]    <= r_addr;
                r_mem_instr[r_wr_ptr] <= bus.imem_rdata;
                r_wr_ptr              <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch
//  Description : Directed self-checking bench for instr_fetch. A small PC
//                register model follows pc_write_en so pc_in tracks fetches
//                and branch targets.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_instr_fetch;

    logic        clk;
    logic        reset;
    logic [31:0] pc_in;
    logic        flush;
    logic        pc_write_en;
    logic        fetch_fault;

    instr_fetch_if bus ();

    instr_fetch #(.DEPTH(2), .TIMEOUT(64)) dut (
        .clk         (clk),
        .reset       (reset),
        .pc_in       (pc_in),
        .flush       (flush),
        .pc_write_en (pc_write_en),
        .fetch_fault (fetch_fault),
        .bus         (bus)
    );

    int          n_pass;
    int          n_total;
    logic        last_we;
    logic        last_fl;
    logic [31:0] branch_target;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: sample pc_write_en mid-cycle, then update the PC model.
    task automatic step();
        @(negedge clk);
        last_we = pc_write_en;
        last_fl = flush;
        @(posedge clk);
        #1;
        if (last_we) pc_in = last_fl ? branch_target : pc_in + 32'd4;
    endtask

    task automatic ack_after(input int n, input logic [31:0] d);
        repeat (n) step();
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = d;
        step();
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'h0;
    endtask

    task automatic test_reset();
        flush = 1'b1;
        step();
        step();
        n_total++; if (last_we !== 1'b0) $display("FAIL rst_we: got %0b want 0", last_we); else n_pass++;
        n_total++; if (bus.imem_req !== 1'b0) $display("FAIL rst_req: got %0b want 0", bus.imem_req); else n_pass++;
        n_total++; if (bus.imem_addr !== 32'h0) $display("FAIL rst_addr: got %h want 0", bus.imem_addr); else n_pass++;
        n_total++; if (bus.if_valid !== 1'b0) $display("FAIL rst_valid: got %0b want 0", bus.if_valid); else n_pass++;
        n_total++; if ({bus.if_pc, bus.if_instr} !== 64'h0) $display("FAIL rst_head: got %h want 0", {bus.if_pc, bus.if_instr}); else n_pass++;
        n_total++; if (fetch_fault !== 1'b0) $display("FAIL rst_fault: got %0b want 0", fetch_fault); else n_pass++;
        flush = 1'b0;
    endtask

    task automatic test_single_fetch();
        reset = 1'b1;
        step();
        n_total++; if (bus.imem_req !== 1'b1) $display("FAIL sf_req: got %0b want 1", bus.imem_req); else n_pass++;
        n_total++; if (bus.imem_addr !== 32'h0) $display("FAIL sf_addr: got %h want 0", bus.imem_addr); else n_pass++;
        ack_after(1, 32'hAAAA0001);
        n_total++; if (last_we !== 1'b1) $display("FAIL sf_we: got %0b want 1", last_we); else n_pass++;
        n_total++; if (bus.if_valid !== 1'b1) $display("FAIL sf_valid: got %0b want 1", bus.if_valid); else n_pass++;
        n_total++; if (bus.if_pc !== 32'h0) $display("FAIL sf_pc: got %h want 0", bus.if_pc); else n_pass++;
        n_total++; if (bus.if_instr !== 32'hAAAA0001) $display("FAIL sf_instr: got %h want aaaa0001", bus.if_instr); else n_pass++;
        n_total++; if (bus.imem_req !== 1'b0) $display("FAIL sf_req_drop: got %0b want 0", bus.imem_req); else n_pass++;
    endtask

    task automatic test_backpressure();
        step();
        n_total++; if (last_we !== 1'b0) $display("FAIL bp_we_once: got %0b want 0", last_we); else n_pass++;
        n_total++; if (bus.imem_addr !== 32'h4) $display("FAIL bp_addr4: got %h want 4", bus.imem_addr); else n_pass++;
        ack_after(1, 32'hBBBB0004);
        for (int i = 0; i < 3; i++) begin
            step();
            n_total++; if (bus.imem_req !== 1'b0) $display("FAIL bp_full_req: got %0b want 0", bus.imem_req); else n_pass++;
        end
        n_total++; if (pc_in !== 32'h8) $display("FAIL bp_pc: got %h want 8", pc_in); else n_pass++;
        n_total++; if (bus.if_pc !== 32'h0) $display("FAIL bp_head0: got %h want 0", bus.if_pc); else n_pass++;
        bus.id_ready = 1'b1;
        step();
        n_total++; if (bus.if_pc !== 32'h4) $display("FAIL bp_head4_pc: got %h want 4", bus.if_pc); else n_pass++;
        n_total++; if (bus.if_instr !== 32'hBBBB0004) $display("FAIL bp_head4_instr: got %h want bbbb0004", bus.if_instr); else n_pass++;
        n_total++; if (bus.imem_req !== 1'b0) $display("FAIL bp_noissue_full: got %0b want 0", bus.imem_req); else n_pass++;
        step();
        n_total++; if (bus.if_valid !== 1'b0) $display("FAIL bp_drained: got %0b want 0", bus.if_valid); else n_pass++;
        n_total++; if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h8}) $display("FAIL bp_resume: got %0b/%h want 1/8", bus.imem_req, bus.imem_addr); else n_pass++;
        bus.id_ready = 1'b0;
        ack_after(0, 32'hCCCC0008);
        n_total++; if ({bus.if_valid, bus.if_pc, bus.if_instr} !== {1'b1, 32'h8, 32'hCCCC0008}) $display("FAIL bp_entry8: got %0b/%h/%h want 1/8/cccc0008", bus.if_valid, bus.if_pc, bus.if_instr); else n_pass++;
        bus.id_ready = 1'b1;
        step();
        n_total++; if ({bus.if_valid, bus.imem_req, bus.imem_addr} !== {1'b0, 1'b1, 32'hC}) $display("FAIL bp_issueC: got %0b/%0b/%h want 0/1/c", bus.if_valid, bus.imem_req, bus.imem_addr); else n_pass++;
        bus.id_ready = 1'b0;
    endtask

    task automatic test_flush_outstanding();
        ack_after(0, 32'hDDDD000C);
        step();
        n_total++; if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h10}) $display("FAIL fl_req10: got %0b/%h want 1/10", bus.imem_req, bus.imem_addr); else n_pass++;
        n_total++; if ({bus.if_valid, bus.if_pc} !== {1'b1, 32'hC}) $display("FAIL fl_queued: got %0b/%h want 1/c", bus.if_valid, bus.if_pc); else n_pass++;
        flush = 1'b1;
        branch_target = 32'h100;
        step();
        flush = 1'b0;
        n_total++; if (last_we !== 1'b1) $display("FAIL fl_we: got %0b want 1", last_we); else n_pass++;
        n_total++; if (bus.if_valid !== 1'b0) $display("FAIL fl_cleared: got %0b want 0", bus.if_valid); else n_pass++;
        n_total++; if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h10}) $display("FAIL fl_held: got %0b/%h want 1/10", bus.imem_req, bus.imem_addr); else n_pass++;
        step();
        n_total++; if (last_we !== 1'b0) $display("FAIL fl_we_once: got %0b want 0", last_we); else n_pass++;
        step();
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hEEEE0010;
        step();
        bus.imem_ack   = 1'b0;
        n_total++; if (last_we !== 1'b0) $display("FAIL fl_drop_we: got %0b want 0", last_we); else n_pass++;
        n_total++; if ({bus.if_valid, bus.imem_req} !== 2'b00) $display("FAIL fl_drop: got %0b/%0b want 0/0", bus.if_valid, bus.imem_req); else n_pass++;
        step();
        n_total++; if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h100}) $display("FAIL fl_newpc: got %0b/%h want 1/100", bus.imem_req, bus.imem_addr); else n_pass++;
    endtask

    task automatic test_flush_with_ack();
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hFFFF0100;
        flush          = 1'b1;
        branch_target  = 32'h200;
        step();
        bus.imem_ack = 1'b0;
        flush        = 1'b0;
        n_total++; if (last_we !== 1'b1) $display("FAIL fa_we: got %0b want 1", last_we); else n_pass++;
        n_total++; if ({bus.if_valid, bus.imem_req} !== 2'b00) $display("FAIL fa_nopush: got %0b/%0b want 0/0", bus.if_valid, bus.imem_req); else n_pass++;
        step();
        n_total++; if (last_we !== 1'b0) $display("FAIL fa_we_once: got %0b want 0", last_we); else n_pass++;
        n_total++; if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h200}) $display("FAIL fa_idle_issue: got %0b/%h want 1/200", bus.imem_req, bus.imem_addr); else n_pass++;
    endtask

    task automatic test_watchdog();
        ack_after(0, 32'h12340200);
        step();
        n_total++; if ({bus.imem_req, bus.imem_addr, bus.if_valid} !== {1'b1, 32'h204, 1'b1}) $display("FAIL wd_start: got %0b/%h/%0b want 1/204/1", bus.imem_req, bus.imem_addr, bus.if_valid); else n_pass++;
        for (int i = 0; i < 63; i++) step();
        n_total++; if ({fetch_fault, bus.imem_req} !== 2'b01) $display("FAIL wd_63: got %0b/%0b want 0/1", fetch_fault, bus.imem_req); else n_pass++;
        step();
        n_total++; if ({fetch_fault, bus.imem_req} !== 2'b10) $display("FAIL wd_64: got %0b/%0b want 1/0", fetch_fault, bus.imem_req); else n_pass++;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h99999999;
        flush          = 1'b1;
        branch_target  = 32'h400;
        step();
        bus.imem_ack = 1'b0;
        flush        = 1'b0;
        step();
        n_total++; if ({fetch_fault, bus.imem_req} !== 2'b10) $display("FAIL wd_absorb: got %0b/%0b want 1/0", fetch_fault, bus.imem_req); else n_pass++;
        n_total++; if ({bus.if_valid, bus.if_pc, bus.if_instr} !== {1'b1, 32'h200, 32'h12340200}) $display("FAIL wd_keepq: got %0b/%h/%h want 1/200/12340200", bus.if_valid, bus.if_pc, bus.if_instr); else n_pass++;
        bus.id_ready = 1'b1;
        step();
        bus.id_ready = 1'b0;
        n_total++; if (bus.if_valid !== 1'b0) $display("FAIL wd_pop: got %0b want 0", bus.if_valid); else n_pass++;
        reset = 1'b0;
        step();
        n_total++; if (fetch_fault !== 1'b0) $display("FAIL wd_reset: got %0b want 0", fetch_fault); else n_pass++;
    endtask

    task automatic test_reset_mid();
        pc_in = 32'h300;
        reset = 1'b1;
        step();
        ack_after(0, 32'h55550300);
        step();
        n_total++; if ({bus.imem_req, bus.imem_addr, bus.if_valid} !== {1'b1, 32'h304, 1'b1}) $display("FAIL rm_pre: got %0b/%h/%0b want 1/304/1", bus.imem_req, bus.imem_addr, bus.if_valid); else n_pass++;
        reset          = 1'b0;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h77777777;
        step();
        bus.imem_ack = 1'b0;
        n_total++; if (last_we !== 1'b0) $display("FAIL rm_we: got %0b want 0", last_we); else n_pass++;
        n_total++; if ({bus.imem_req, bus.if_valid, bus.imem_addr} !== {1'b0, 1'b0, 32'h0}) $display("FAIL rm_clear: got %0b/%0b/%h want 0/0/0", bus.imem_req, bus.if_valid, bus.imem_addr); else n_pass++;
        step();
        reset = 1'b1;
        step();
        n_total++; if ({bus.imem_req, bus.imem_addr, bus.if_valid} !== {1'b1, 32'h304, 1'b0}) $display("FAIL rm_restart: got %0b/%h/%0b want 1/304/0", bus.imem_req, bus.imem_addr, bus.if_valid); else n_pass++;
    endtask

    initial begin
        n_pass         = 0;
        n_total        = 0;
        last_we        = 1'b0;
        last_fl        = 1'b0;
        branch_target  = 32'h0;
        reset          = 1'b0;
        pc_in          = 32'h0;
        flush          = 1'b0;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'h0;
        bus.id_ready   = 1'b0;
        test_reset();
        test_single_fetch();
        test_backpressure();
        test_flush_outstanding();
        test_flush_with_ack();
        test_watchdog();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, passed %0d of %0d", n_pass, n_total);
        $fatal(1);
    end

endmodule
`default_nettype wire
